// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed hex display driver.
// Scans N_DIGITS digits from one shared segment bus, one digit per DIV-cycle slot.
// The displayed value is double-buffered (stage -> shadow) and only swapped at a
// frame boundary, so a frame never mixes old and new digits.
// Supports leading-zero blanking, decimal points, and configurable pin polarity.
// All pin outputs come directly from flops.
module seg7_scan_driver #(
    parameter int N_DIGITS   = 4,
    parameter int DIV        = 50000,
    parameter int SEG_ACT_LO = 1,
    parameter int AN_ACT_LO  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    blank_lz,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic                    upd_ack,
    output logic                    frame_done,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an
);

    localparam int   CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic SEG_INV = (SEG_ACT_LO != 0);
    localparam logic AN_INV  = (AN_ACT_LO != 0);

    // Active-high segment pattern {a,b,c,d,e,f,g} for one hex nibble
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
            4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
            4'h8: s = 7'h7F;  4'h9: s = 7'h7B;  4'hA: s = 7'h77;  4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;  4'hD: s = 7'h3D;  4'hE: s = 7'h4F;  default: s = 7'h47;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] stage_q, stage_d, shadow_q, shadow_d;
    logic [N_DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
    logic                  pending_q, pending_d;
    logic                  upd_ack_q, upd_ack_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;

    logic tick, wrap;

    // Prescaler, digit index and the stage/shadow handshake
    always_comb begin
        tick         = en && (cnt_q == CNT_W'(DIV - 1));
        wrap         = tick && (idx_q == IDX_W'(N_DIGITS - 1));
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        stage_d      = stage_q;
        stage_dp_d   = stage_dp_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        upd_ack_d    = 1'b0;
        frame_done_d = wrap;

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end

        if (wrap && load) begin
            // Fresh request on the boundary bypasses the stage buffer
            shadow_d    = value;
            shadow_dp_d = dp_in;
            pending_d   = 1'b0;
            upd_ack_d   = 1'b1;
        end else begin
            if (wrap && pending_q) begin
                shadow_d    = stage_q;
                shadow_dp_d = stage_dp_q;
                pending_d   = 1'b0;
                upd_ack_d   = 1'b1;
            end
            if (load) begin
                stage_d    = value;
                stage_dp_d = dp_in;
                pending_d  = 1'b1;
            end
        end
    end

    // Next pin levels for the digit currently selected by idx
    always_comb begin
        logic [4*N_DIGITS-1:0] upper;
        logic [3:0]            nib;
        logic                  dark;
        logic [6:0]            seg_act;
        logic                  dp_act;
        logic [N_DIGITS-1:0]   an_act;

        upper   = shadow_q >> {idx_q, 2'b00};
        nib     = upper[3:0];
        // Digit 0 is never blanked; higher digits go dark if they and everything above are zero
        dark    = blank_lz && (idx_q != '0) && (upper == '0);
        seg_act = dark ? 7'h00 : hex_decode(nib);
        dp_act  = !dark && shadow_dp_q[idx_q];
        an_act  = N_DIGITS'(1) << idx_q;
        if (!en) begin
            seg_act = 7'h00;
            dp_act  = 1'b0;
            an_act  = '0;
        end
        seg_d = seg_act ^ {7{SEG_INV}};
        dp_d  = dp_act ^ SEG_INV;
        an_d  = an_act ^ {N_DIGITS{AN_INV}};
    end

    // State and output registers; pins reset to their inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_q      <= '0;
            stage_dp_q   <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            upd_ack_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= {7{SEG_INV}};
            dp_q         <= SEG_INV;
            an_q         <= {N_DIGITS{AN_INV}};
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_q      <= stage_d;
            stage_dp_q   <= stage_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            upd_ack_q    <= upd_ack_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign upd_ack    = upd_ack_q;
    assign frame_done = frame_done_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (N_DIGITS=4, DIV=4, active-low pins).
// Randomized stimulus compared every cycle against a slot-position model.
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int TOT = N * DIV;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, blank_lz, load;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          upd_ack, frame_done, dp;
    logic [6:0]    seg;
    logic [3:0]    an;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.N_DIGITS(N), .DIV(DIV), .SEG_ACT_LO(1), .AN_ACT_LO(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .blank_lz(blank_lz), .load(load),
        .value(value), .dp_in(dp_in), .upd_ack(upd_ack), .frame_done(frame_done),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    // Reference model: one integer slot position across the whole frame
    logic [6:0]  hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    int          pos;
    logic [15:0] m_stage, m_shown;
    logic [3:0]  m_stage_dp, m_shown_dp;
    bit          m_pend;
    logic [6:0]  e_seg;
    logic        e_dp, e_ack, e_fd;
    logic [3:0]  e_an;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; m_stage = '0; m_shown = '0; m_stage_dp = '0; m_shown_dp = '0; m_pend = 0;
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ack = 1'b0; e_fd = 1'b0;
    endtask

    task automatic model_step();
        int  d;
        bit  dark, wrap;
        logic [15:0] upper;
        d     = pos / DIV;
        upper = m_shown >> (4 * d);
        dark  = blank_lz && (d > 0) && (upper == 16'h0);
        if (!en) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end else begin
            e_seg = dark ? 7'h7F : ~hex_tab[upper[3:0]];
            e_dp  = dark ? 1'b1 : ~m_shown_dp[d];
            e_an  = ~(4'b0001 << d);
        end
        wrap  = en && (pos == TOT - 1);
        e_fd  = wrap;
        e_ack = 1'b0;
        if (wrap && load) begin
            m_shown = value; m_shown_dp = dp_in; m_pend = 0; e_ack = 1'b1;
        end else begin
            if (wrap && m_pend) begin
                m_shown = m_stage; m_shown_dp = m_stage_dp; m_pend = 0; e_ack = 1'b1;
            end
            if (load) begin
                m_stage = value; m_stage_dp = dp_in; m_pend = 1;
            end
        end
        if (en) pos = (pos + 1) % TOT;
    endtask

    task automatic compare_all();
        check_val("seg", 32'(seg), 32'(e_seg));
        check_val("dp", 32'(dp), 32'(e_dp));
        check_val("an", 32'(an), 32'(e_an));
        check_val("upd_ack", 32'(upd_ack), 32'(e_ack));
        check_val("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    // Assert reset between edges and confirm the pins drop to defaults immediately
    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_an", 32'(an), 32'hF);
        check_val("rst_seg", 32'(seg), 32'h7F);
        check_val("rst_dp", 32'(dp), 32'h1);
        check_val("rst_ack", 32'(upd_ack), 32'h0);
        check_val("rst_fd", 32'(frame_done), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; blank_lz = 1'b0; load = 1'b0; value = '0; dp_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_an", 32'(an), 32'hF);
        check_val("rst_seg", 32'(seg), 32'h7F);
        check_val("rst_dp", 32'(dp), 32'h1);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) async_reset();
            // Drive inputs for the next edge
            en       = !((cyc > 400) && (cyc % 300 > 270)) && ($urandom_range(0, 49) != 0);
            blank_lz = ((cyc / 250) % 2) == 1;
            if (cyc == 0) begin
                load = 1'b1; value = 16'h1234; dp_in = 4'b0000;
            end else if (cyc < 100) begin
                load = 1'b0;
            end else if (cyc >= 2000 && cyc < 2400) begin
                load = (pos == TOT - 1) && ($urandom_range(0, 1) == 1);
            end else begin
                load = ($urandom_range(0, 19) == 0);
            end
            case ($urandom_range(0, 3))
                0:       value = 16'h0000;
                1:       value = {8'h00, 8'($urandom)};
                2:       value = {12'h000, 4'($urandom)};
                default: value = 16'($urandom);
            endcase
            if (cyc == 0) value = 16'h1234;
            dp_in = 4'($urandom);
            if (cyc == 0) dp_in = 4'b0000;
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
